regfile_wb_sched: RTL and testbench

Write-port scheduler for the 32x32 register file. Three writeback sources share its single write port: ALU result, memory load and JAL link. Each source gets a one-entry holding buffer with a valid/ready handshake. The scheduler serves them round-robin, preserves write ordering per register and exports a pending-write mask for hazard detection. It sits between the pipeline writeback stage and the register file's write_data/write/RegWrite inputs.

---
 rtl/regfile_wb_sched_if.sv | 39 +++
 rtl/regfile_wb_sched.sv | 131 +++++++++++++
 tb/tb_regfile_wb_sched.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_sched_if.sv
// Writeback request bus between the pipeline writeback stage and the write-port scheduler.
// Carries the three source handshakes, the registered write port and the hazard outputs.
interface regfile_wb_sched_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          link_valid;
    logic          link_ready;
    logic [DW-1:0] link_data;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [(1<<AW)-1:0] pend_mask;
    logic          idle;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output link_valid, link_data,
        input  alu_ready, mem_ready, link_ready,
        input  rf_we, rf_waddr, rf_wdata, pend_mask, idle
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  link_valid, link_data,
        output alu_ready, mem_ready, link_ready,
        output rf_we, rf_waddr, rf_wdata, pend_mask, idle
    );
endinterface

// File: rtl/regfile_wb_sched.sv
// Register-file write-port scheduler: one holding entry per source (0=ALU, 1=MEM, 2=LINK),
// round-robin grant into a registered write port, per-register ordering via collision stalls.
module regfile_wb_sched #(
    parameter int NSRC = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_wb_sched_if.slave   bus
);
    localparam int PW = $clog2(NSRC);

    logic [NSRC-1:0] hv;
    logic [AW-1:0]   ha [NSRC];
    logic [DW-1:0]   hd [NSRC];
    logic [PW-1:0]   rr_ptr;

    logic [NSRC-1:0] valid, ready, coll, grant, accept;
    logic [AW-1:0]   addr [NSRC];
    logic [DW-1:0]   data [NSRC];
    logic            any_grant;
    logic [PW-1:0]   win;

    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic [(1<<AW)-1:0] pm;

    assign valid = {bus.link_valid, bus.mem_valid, bus.alu_valid};

    always_comb begin
        addr[0] = bus.alu_addr;
        addr[1] = bus.mem_addr;
        addr[2] = AW'(31);
        data[0] = bus.alu_data;
        data[1] = bus.mem_data;
        data[2] = bus.link_data;
    end

    // A held entry stalls others for its register until it is granted; among same-cycle
    // requests for one register the higher index wins, so no two held entries alias.
    always_comb begin
        coll = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (addr[i] != '0) begin
                for (int unsigned j = 0; j < NSRC; j++) begin
                    if (j != i && hv[j] && ha[j] == addr[i])
                        coll[i] = 1'b1;
                    if (j > i && valid[j] && addr[j] == addr[i])
                        coll[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        win       = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            int unsigned idx;
            idx = (int'(rr_ptr) + k) % NSRC;
            if (!any_grant && hv[idx]) begin
                any_grant  = 1'b1;
                win        = PW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    assign ready  = (~hv | grant) & ~coll;
    assign accept = valid & ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hv     <= '0;
            rr_ptr <= '0;
            for (int unsigned i = 0; i < NSRC; i++) begin
                ha[i] <= '0;
                hd[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                if (accept[i]) begin
                    // r0 requests complete the handshake but are never held
                    hv[i] <= (addr[i] != '0);
                    ha[i] <= addr[i];
                    hd[i] <= data[i];
                end else if (grant[i]) begin
                    hv[i] <= 1'b0;
                end
            end
            if (any_grant)
                rr_ptr <= (int'(win) == NSRC - 1) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (any_grant) begin
            rf_we    <= 1'b1;
            rf_waddr <= ha[win];
            rf_wdata <= hd[win];
        end else begin
            rf_we    <= 1'b0;
        end
    end

    always_comb begin
        pm = '0;
        for (int unsigned i = 0; i < NSRC; i++)
            if (hv[i])
                pm[ha[i]] = 1'b1;
        if (rf_we)
            pm[rf_waddr] = 1'b1;
        pm[0] = 1'b0;
    end

    assign bus.alu_ready  = ready[0];
    assign bus.mem_ready  = ready[1];
    assign bus.link_ready = ready[2];
    assign bus.rf_we      = rf_we;
    assign bus.rf_waddr   = rf_waddr;
    assign bus.rf_wdata   = rf_wdata;
    assign bus.pend_mask  = pm;
    assign bus.idle       = ~|hv & ~rf_we;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: hand-computed vectors, write log and shadow register file.
module tb_regfile_wb_sched;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    regfile_wb_sched_if #(.DW(32), .AW(5)) bus ();

    regfile_wb_sched #(.NSRC(3), .DW(32), .AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  log_addr [$];
    logic [31:0] log_data [$];
    logic [31:0] shadow_rf [32];

    always @(posedge clk) begin
        if (bus.rf_we) begin
            log_addr.push_back(bus.rf_waddr);
            log_data.push_back(bus.rf_wdata);
            shadow_rf[bus.rf_waddr] = bus.rf_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid  = 1'b0;
        bus.alu_addr   = '0;
        bus.alu_data   = '0;
        bus.mem_valid  = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_data   = '0;
        bus.link_valid = 1'b0;
        bus.link_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #1 rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int n1, n2, n31;
        bit acc;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        for (int i = 0; i < 32; i++) shadow_rf[i] = '0;

        // reset state
        do_reset();
        check("rst_we",    32'(bus.rf_we), 32'd0);
        check("rst_waddr", 32'(bus.rf_waddr), 32'd0);
        check("rst_wdata", bus.rf_wdata, 32'd0);
        check("rst_pend",  bus.pend_mask, 32'd0);
        check("rst_idle",  32'(bus.idle), 32'd1);
        check("rst_ready", {29'd0, bus.link_ready, bus.mem_ready, bus.alu_ready}, 32'h7);

        // single ALU write r5
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'hDEADBEEF;
        #1 check("t1_ready", 32'(bus.alu_ready), 32'd1);
        step();
        bus.alu_valid = 1'b0;
        check("t1_pend_held", bus.pend_mask, 32'h20);
        check("t1_we_early",  32'(bus.rf_we), 32'd0);
        check("t1_idle_busy", 32'(bus.idle), 32'd0);
        step();
        check("t1_we",    32'(bus.rf_we), 32'd1);
        check("t1_waddr", 32'(bus.rf_waddr), 32'd5);
        check("t1_wdata", bus.rf_wdata, 32'hDEADBEEF);
        check("t1_pend_out", bus.pend_mask, 32'h20);
        step();
        check("t1_we_off", 32'(bus.rf_we), 32'd0);
        check("t1_pend_clr", bus.pend_mask, 32'd0);
        check("t1_idle", 32'(bus.idle), 32'd1);

        // three sources on one edge, fresh pointer
        do_reset();
        bus.alu_valid = 1'b1;  bus.alu_addr = 5'd3; bus.alu_data = 32'hA3;
        bus.mem_valid = 1'b1;  bus.mem_addr = 5'd4; bus.mem_data = 32'hB4;
        bus.link_valid = 1'b1; bus.link_data = 32'h100;
        #1 check("t2_ready", {29'd0, bus.link_ready, bus.mem_ready, bus.alu_ready}, 32'h7);
        step();
        idle_inputs();
        check("t2_pend", bus.pend_mask, 32'h8000_0018);
        step();
        check("t2_g0_addr", 32'(bus.rf_waddr), 32'd3);
        check("t2_g0_data", bus.rf_wdata, 32'hA3);
        step();
        check("t2_g1_addr", 32'(bus.rf_waddr), 32'd4);
        check("t2_g1_we",   32'(bus.rf_we), 32'd1);
        step();
        check("t2_g2_addr", 32'(bus.rf_waddr), 32'd31);
        check("t2_g2_data", bus.rf_wdata, 32'h100);
        step();
        check("t2_done_we", 32'(bus.rf_we), 32'd0);

        // held ALU r7 stalls MEM r7 (pointer back at 0)
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd7; bus.alu_data = 32'h1111_0007;
        step();
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd7; bus.mem_data = 32'h2222_0007;
        #1 check("t3_mem_stall", 32'(bus.mem_ready), 32'd0);
        step();
        check("t3_first_data", bus.rf_wdata, 32'h1111_0007);
        check("t3_mem_ready", 32'(bus.mem_ready), 32'd1);
        step();
        bus.mem_valid = 1'b0;
        check("t3_gap_we", 32'(bus.rf_we), 32'd0);
        check("t3_pend_mem", bus.pend_mask, 32'h80);
        step();
        check("t3_second_addr", 32'(bus.rf_waddr), 32'd7);
        check("t3_second_data", bus.rf_wdata, 32'h2222_0007);
        step();
        check("t3_r7_final", shadow_rf[7], 32'h2222_0007);

        // ALU and LINK both target r31 with empty buffers
        log_addr.delete(); log_data.delete();
        bus.alu_valid = 1'b1;  bus.alu_addr = 5'd31; bus.alu_data = 32'hA1A1_0031;
        bus.link_valid = 1'b1; bus.link_data = 32'h0000_4004;
        #1 check("t4_alu_blocked", 32'(bus.alu_ready), 32'd0);
        check("t4_link_ready", 32'(bus.link_ready), 32'd1);
        step();
        bus.link_valid = 1'b0;
        acc = 1'b0;
        for (int c = 0; c < 8; c++) begin
            bit take;
            take = bus.alu_valid && bus.alu_ready;
            step();
            if (take) begin
                bus.alu_valid = 1'b0;
                acc = 1'b1;
            end
        end
        check("t4_alu_accepted", 32'(acc), 32'd1);
        check("t4_nwrites", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            check("t4_first",  log_data[0], 32'h0000_4004);
            check("t4_last",   log_data[1], 32'hA1A1_0031);
        end
        check("t4_r31", shadow_rf[31], 32'hA1A1_0031);

        // write to r0 is swallowed
        log_addr.delete(); log_data.delete();
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd0; bus.alu_data = 32'h1234;
        #1 check("t5_ready", 32'(bus.alu_ready), 32'd1);
        step();
        bus.alu_valid = 1'b0;
        check("t5_pend", bus.pend_mask, 32'd0);
        check("t5_idle", 32'(bus.idle), 32'd1);
        step();
        check("t5_we", 32'(bus.rf_we), 32'd0);
        step();
        check("t5_nwrites", 32'(log_addr.size()), 32'd0);

        // all three streaming, then reset mid-stream
        bus.alu_valid = 1'b1;  bus.alu_addr = 5'd1; bus.alu_data = 32'hA0;
        bus.mem_valid = 1'b1;  bus.mem_addr = 5'd2; bus.mem_data = 32'hB0;
        bus.link_valid = 1'b1; bus.link_data = 32'hC0;
        step();
        n1 = 0; n2 = 0; n31 = 0;
        for (int c = 0; c < 9; c++) begin
            step();
            check("t6_we_stream", 32'(bus.rf_we), 32'd1);
            if (bus.rf_waddr == 5'd1) n1++;
            if (bus.rf_waddr == 5'd2) n2++;
            if (bus.rf_waddr == 5'd31) n31++;
            bus.alu_data = bus.alu_data + 1;
        end
        check("t6_share_alu",  32'(n1), 32'd3);
        check("t6_share_mem",  32'(n2), 32'd3);
        check("t6_share_link", 32'(n31), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_we",   32'(bus.rf_we), 32'd0);
        check("t6_rst_idle", 32'(bus.idle), 32'd1);
        check("t6_rst_pend", bus.pend_mask, 32'd0);
        idle_inputs();
        log_addr.delete(); log_data.delete();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) step();
        check("t6_no_writes", 32'(log_addr.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
